// File: rtl/data_ram_pkg.sv
// data_ram_pkg
// Shared definitions for the data-memory byte-pair responder:
//   - state_e           : sequencer states (array clear, normal service)
//   - DEFAULT_ADDR_BITS : default log2 of the array depth in bytes
//   - READ_MISS_BYTE    : byte returned by an out-of-range read
//   - CLEAR_BYTE        : byte written to every location by the clear sequence
package data_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int          DEFAULT_ADDR_BITS = 12;
    localparam logic [7:0]  READ_MISS_BYTE    = 8'h00;
    localparam logic [7:0]  CLEAR_BYTE        = 8'h00;

endpackage : data_ram_pkg

// File: rtl/dpram_byte.sv
// dpram_byte
// True dual-port byte array, 2^ADDR_BITS x 8, no reset.
// Reads are asynchronous: the read data reflects the array contents before
// the write at the coming clock edge, so a registered consumer sees
// read-first behaviour on both ports. When both ports write the same
// address in one cycle, port A's byte is stored and port B's is dropped.
// Ports:
//   clk        in   rising-edge clock
//   a_we_i     in   port A write enable
//   a_addr_i   in   port A byte offset
//   a_wdata_i  in   port A write byte
//   a_rdata_o  out  port A read byte (current contents)
//   b_*        same as a_* for port B
module dpram_byte #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 a_we_i,
    input  logic [ADDR_BITS-1:0] a_addr_i,
    input  logic [7:0]           a_wdata_i,
    output logic [7:0]           a_rdata_o,
    input  logic                 b_we_i,
    input  logic [ADDR_BITS-1:0] b_addr_i,
    input  logic [7:0]           b_wdata_i,
    output logic [7:0]           b_rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [7:0] mem_q [DEPTH];
    logic       b_collide_s;

    // Port B loses to port A when both write the same byte.
    assign b_collide_s = a_we_i && (a_addr_i == b_addr_i);

    // Array write ports.
    always_ff @(posedge clk) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_wdata_i;
        end
        if (b_we_i && !b_collide_s) begin
            mem_q[b_addr_i] <= b_wdata_i;
        end
    end

    assign a_rdata_o = mem_q[a_addr_i];
    assign b_rdata_o = mem_q[b_addr_i];

endmodule : dpram_byte

// File: rtl/data_ram_responder.sv
// data_ram_responder
// Memory-side responder for the load/store unit's byte-pair data port.
// Services two byte lanes per enabled cycle with registered read data,
// zeroes the array after reset or on clear_req, and records the first
// out-of-range address in a sticky error flag.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                request valid for both lanes
//   wea / web         lane write enables (qualified by en)
//   addr_a / addr_b   lane byte addresses (absolute, BASE_ADDR-relative map)
//   data_a / data_b   lane write bytes
//   clear_req         pulse: start an array clear (honoured in IDLE)
//   recv_data_a / _b  registered lane read bytes
//   ready             1 when servicing requests, 0 while clearing
//   err / err_addr    sticky out-of-range flag and first offending address
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int          ADDR_BITS = DEFAULT_ADDR_BITS,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wea,
    input  logic        web,
    input  logic [31:0] addr_a,
    input  logic [7:0]  data_a,
    input  logic [31:0] addr_b,
    input  logic [7:0]  data_b,
    input  logic        clear_req,
    output logic [7:0]  recv_data_a,
    output logic [7:0]  recv_data_b,
    output logic        ready,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int                CNT_BITS = ADDR_BITS - 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = {CNT_BITS{1'b1}};

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [7:0]          recv_a_q, recv_a_d;
    logic [7:0]          recv_b_q, recv_b_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [31:0]         err_addr_q, err_addr_d;

    logic [31:0]          offset_a_s, offset_b_s;
    logic                 in_a_s, in_b_s;
    logic                 access_s;
    logic                 ram_a_we_s, ram_b_we_s;
    logic [ADDR_BITS-1:0] ram_a_addr_s, ram_b_addr_s;
    logic [7:0]           ram_a_wdata_s, ram_b_wdata_s;
    logic [7:0]           ram_a_rdata_s, ram_b_rdata_s;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign offset_a_s = addr_a - BASE_ADDR;
    assign offset_b_s = addr_b - BASE_ADDR;
    assign in_a_s     = ((offset_a_s >> ADDR_BITS) == 32'd0);
    assign in_b_s     = ((offset_b_s >> ADDR_BITS) == 32'd0);
    assign access_s   = (state_q == ST_IDLE) && en;

    // RAM port muxing: clear sequencer writes an even/odd byte pair per cycle.
    always_comb begin
        ram_a_we_s    = 1'b0;
        ram_a_addr_s  = offset_a_s[ADDR_BITS-1:0];
        ram_a_wdata_s = data_a;
        ram_b_we_s    = 1'b0;
        ram_b_addr_s  = offset_b_s[ADDR_BITS-1:0];
        ram_b_wdata_s = data_b;
        if (state_q == ST_CLEAR) begin
            ram_a_we_s    = 1'b1;
            ram_a_addr_s  = {cnt_q, 1'b0};
            ram_a_wdata_s = CLEAR_BYTE;
            ram_b_we_s    = 1'b1;
            ram_b_addr_s  = {cnt_q, 1'b1};
            ram_b_wdata_s = CLEAR_BYTE;
        end else begin
            ram_a_we_s = access_s && wea && in_a_s;
            ram_b_we_s = access_s && web && in_b_s;
        end
    end

    dpram_byte #(
        .ADDR_BITS (ADDR_BITS)
    ) u_dpram (
        .clk       (clk),
        .a_we_i    (ram_a_we_s),
        .a_addr_i  (ram_a_addr_s),
        .a_wdata_i (ram_a_wdata_s),
        .a_rdata_o (ram_a_rdata_s),
        .b_we_i    (ram_b_we_s),
        .b_addr_i  (ram_b_addr_s),
        .b_wdata_i (ram_b_wdata_s),
        .b_rdata_o (ram_b_rdata_s)
    );

    // Next-state logic: sequencer, read-data capture and error capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        recv_a_d   = recv_a_q;
        recv_b_d   = recv_b_q;
        ready_d    = ready_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;

        if (access_s) begin
            recv_a_d = in_a_s ? ram_a_rdata_s : READ_MISS_BYTE;
            recv_b_d = in_b_s ? ram_b_rdata_s : READ_MISS_BYTE;
            if (!in_a_s || !in_b_s) begin
                err_d = 1'b1;
                // Only the first offender is recorded; lane A wins a tie.
                if (!err_q) begin
                    err_addr_d = !in_a_s ? addr_a : addr_b;
                end else begin
                    err_addr_d = err_addr_q;
                end
            end else begin
                err_d = err_q;
            end
        end else begin
            recv_a_d = recv_a_q;
            recv_b_d = recv_b_q;
        end

        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_BITS{1'b0}};
                    ready_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
                    ready_d = 1'b0;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    // The request in this cycle is still serviced above;
                    // the error record is wiped as the clear starts.
                    state_d    = ST_CLEAR;
                    cnt_d      = {CNT_BITS{1'b0}};
                    ready_d    = 1'b0;
                    err_d      = 1'b0;
                    err_addr_d = 32'h0000_0000;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {CNT_BITS{1'b0}};
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= {CNT_BITS{1'b0}};
            recv_a_q   <= 8'h00;
            recv_b_q   <= 8'h00;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            recv_a_q   <= recv_a_d;
            recv_b_q   <= recv_b_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign recv_data_a = recv_a_q;
    assign recv_data_b = recv_b_q;
    assign ready       = ready_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;

endmodule : data_ram_responder

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder at depth 16 (ADDR_BITS=4).
// Requests push their hand-computed read pair into a queue; a monitor pops
// and compares one cycle after each accepted request.
module tb_data_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, wea, web, clear_req;
    logic [31:0] addr_a, addr_b;
    logic [7:0]  data_a, data_b;
    logic [7:0]  recv_data_a, recv_data_b;
    logic        ready, err;
    logic [31:0] err_addr;

    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc;

    always #5 clk = ~clk;

    data_ram_responder #(
        .ADDR_BITS (4),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .wea         (wea),
        .web         (web),
        .addr_a      (addr_a),
        .data_a      (data_a),
        .addr_b      (addr_b),
        .data_b      (data_b),
        .clear_req   (clear_req),
        .recv_data_a (recv_data_a),
        .recv_data_b (recv_data_b),
        .ready       (ready),
        .err         (err),
        .err_addr    (err_addr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one two-lane request; expected read pair {lane A, lane B}.
    task automatic req(input logic wa, input logic [31:0] aa, input logic [7:0] da,
                       input logic wb, input logic [31:0] ab, input logic [7:0] db,
                       input logic [7:0] ea, input logic [7:0] eb);
        @(negedge clk);
        en = 1'b1; wea = wa; addr_a = aa; data_a = da;
        web = wb; addr_b = ab; data_b = db;
        exp_q.push_back({ea, eb});
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; wea = 1'b0; web = 1'b0;
    endtask

    // Counts rising edges until ready is seen high, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Monitor: every accepted request yields a read pair one edge later.
    always @(posedge clk) begin
        if (rst_n && en && ready) begin
            #1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got 0x%0h, expected no response",
                         {recv_data_a, recv_data_b});
            end else begin
                mon_exp = exp_q.pop_front();
                check("recv_pair", {16'h0000, recv_data_a, recv_data_b}, {16'h0000, mon_exp});
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; wea = 1'b0; web = 1'b0; clear_req = 1'b0;
        addr_a = 32'h0; addr_b = 32'h0; data_a = 8'h00; data_b = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_recv_a", {24'h0, recv_data_a}, 32'h0);
        check("rst_recv_b", {24'h0, recv_data_b}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_err_addr", err_addr, 32'h0);

        // Initial clear takes 8 cycles at depth 16.
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n_cyc);
        check("init_clear_cycles", n_cyc, 32'd8);

        for (int i = 0; i < 8; i++) begin
            req(1'b0, 32'(2*i), 8'h00, 1'b0, 32'(2*i+1), 8'h00, 8'h00, 8'h00);
        end

        // Basic write then read back.
        req(1'b1, 32'h0, 8'h12, 1'b1, 32'h1, 8'h34, 8'h00, 8'h00);
        req(1'b0, 32'h0, 8'h00, 1'b0, 32'h1, 8'h00, 8'h12, 8'h34);

        // Read-first: preload 0xAA, then overwrite while B reads it.
        req(1'b1, 32'h3, 8'hAA, 1'b0, 32'h2, 8'h00, 8'h00, 8'h00);
        req(1'b1, 32'h3, 8'h55, 1'b0, 32'h3, 8'h00, 8'hAA, 8'hAA);
        req(1'b0, 32'h3, 8'h00, 1'b0, 32'h0, 8'h00, 8'h55, 8'h12);

        // Same-address double write: lane A wins.
        req(1'b1, 32'h5, 8'h11, 1'b1, 32'h5, 8'h22, 8'h00, 8'h00);
        req(1'b0, 32'h5, 8'h00, 1'b0, 32'h5, 8'h00, 8'h11, 8'h11);

        // Out-of-range lanes; 0x20 would alias offset 0 if not suppressed.
        req(1'b0, 32'h10, 8'h00, 1'b1, 32'h20, 8'h77, 8'h00, 8'h00);
        req(1'b1, 32'h30, 8'h66, 1'b0, 32'h0, 8'h00, 8'h00, 8'h12);
        req(1'b0, 32'h0, 8'h00, 1'b0, 32'h1, 8'h00, 8'h12, 8'h34);
        idle();
        check("err_set", {31'h0, err}, 32'h1);
        check("err_addr_first", err_addr, 32'h10);

        // Clear request wipes the error record and the array.
        @(negedge clk);
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        check("clr_ready_low", {31'h0, ready}, 32'h0);
        check("clr_err", {31'h0, err}, 32'h0);
        check("clr_err_addr", err_addr, 32'h0);
        @(negedge clk);
        clear_req = 1'b0;
        wait_ready(n_cyc);
        check("req_clear_cycles", n_cyc, 32'd8);
        for (int i = 0; i < 8; i++) begin
            req(1'b0, 32'(2*i), 8'h00, 1'b0, 32'(2*i+1), 8'h00, 8'h00, 8'h00);
        end

        // Reset in the middle of a clear.
        req(1'b1, 32'h7, 8'h99, 1'b0, 32'h6, 8'h00, 8'h00, 8'h00);
        req(1'b0, 32'h7, 8'h00, 1'b0, 32'h6, 8'h00, 8'h99, 8'h00);
        idle();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_in_clear", {24'h0, recv_data_a}, 32'h99);
        rst_n = 1'b0;
        #1;
        check("midclr_rst_recv_a", {24'h0, recv_data_a}, 32'h0);
        check("midclr_rst_ready", {31'h0, ready}, 32'h0);
        check("midclr_rst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(n_cyc);
        check("restart_clear_cycles", n_cyc, 32'd8);
        req(1'b0, 32'h7, 8'h00, 1'b0, 32'h3, 8'h00, 8'h00, 8'h00);
        idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_ram_responder
